// File: rtl/axi_lite_mem_slave_v2_if.sv
// AXI-Lite bus bundle for the memory slave: AW, W, B, AR and R channels.
// Clock and reset stay plain ports on the modules that use this bundle.
interface axi_lite_mem_slave_v2_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_mem_slave_v2.sv
// AXI-Lite slave over a word-addressed memory with byte strobes, independent
// AW/W acceptance, window decode (DECERR on miss) and independent read path.
module axi_lite_mem_slave_v2 #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axi_lite_mem_slave_v2_if.slave s
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [0:0] W_COLLECT = 1'b0;
  localparam logic [0:0] W_RESP    = 1'b1;
  localparam logic [0:0] R_IDLE    = 1'b0;
  localparam logic [0:0] R_DATA    = 1'b1;

  // Borrow out of the subtraction marks addresses below the window.
  function automatic logic hit_f(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return !diff[ADDR_WIDTH] && ((diff[ADDR_WIDTH-1:0] >> OFFS) < ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [IDXW-1:0] idx_f(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDXW'(off >> OFFS);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  init_q;
  logic [0:0]            w_state, r_state;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      wstrb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  awready, wready, arready;
  logic                  aw_hs, w_hs, ar_hs, commit, wr_hit, we;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [BYTES-1:0]      wstrb_c;

  // Readies come from state only, so there is no input-to-output path.
  assign awready = init_q && (w_state == W_COLLECT) && !aw_held;
  assign wready  = init_q && (w_state == W_COLLECT) && !w_held;
  assign arready = init_q && (r_state == R_IDLE);

  assign aw_hs   = s.AWVALID && awready;
  assign w_hs    = s.WVALID  && wready;
  assign ar_hs   = s.ARVALID && arready;

  // The half arriving this cycle bypasses its holding register.
  assign addr_c  = aw_held ? awaddr_q : s.AWADDR;
  assign wdata_c = w_held  ? wdata_q  : s.WDATA;
  assign wstrb_c = w_held  ? wstrb_q  : s.WSTRB;
  assign commit  = (w_state == W_COLLECT) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_hit  = hit_f(addr_c);
  assign we      = commit && wr_hit;

  assign s.AWREADY = awready;
  assign s.WREADY  = wready;
  assign s.ARREADY = arready;
  assign s.BVALID  = bvalid_q;
  assign s.BRESP   = bresp_q;
  assign s.RVALID  = rvalid_q;
  assign s.RRESP   = rresp_q;
  assign s.RDATA   = rdata_q;

  always_ff @(posedge ACLK) begin
    if (we)
      for (int b = 0; b < BYTES; b++)
        if (wstrb_c[b]) mem[idx_f(addr_c)][b*8 +: 8] <= wdata_c[b*8 +: 8];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      init_q   <= 1'b0;
      w_state  <= W_COLLECT;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      init_q <= 1'b1;
      if (w_state == W_COLLECT) begin
        if (commit) begin
          bvalid_q <= 1'b1;
          bresp_q  <= wr_hit ? RESP_OKAY : RESP_DECERR;
          w_state  <= W_RESP;
          aw_held  <= 1'b0;
          w_held   <= 1'b0;
        end else begin
          if (aw_hs) begin
            aw_held  <= 1'b1;
            awaddr_q <= s.AWADDR;
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= s.WDATA;
            wstrb_q <= s.WSTRB;
          end
        end
      end else if (s.BREADY) begin
        bvalid_q <= 1'b0;
        w_state  <= W_COLLECT;
      end
    end
  end

  // Memory write above is non-blocking, so a same-edge read sees old data.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state  <= R_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        rdata_q  <= hit_f(s.ARADDR) ? mem[idx_f(s.ARADDR)] : '0;
        rresp_q  <= hit_f(s.ARADDR) ? RESP_OKAY : RESP_DECERR;
        rvalid_q <= 1'b1;
        r_state  <= R_DATA;
      end
    end else if (s.RREADY) begin
      rvalid_q <= 1'b0;
      r_state  <= R_IDLE;
    end
  end
endmodule

// File: doc/axi_lite_mem_slave_v2.md
Name: axi_lite_mem_slave_v2

Overview:
Parametrised AXI-Lite slave fronting an internal word-addressed memory. It is the next-generation memory slave of the verification target family. Compared with the first generation it adds byte strobes, independent acceptance of the AW and W channels, an address decode with error responses, and configurable data width and depth. It sits as the DUT behind the AXI-Lite agent.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, data width; legal values are 32 or 64.
MEM_DEPTH, 256, number of DATA_WIDTH words; power of two, at least 2.
BASE_ADDR, 0, byte base address of the memory window; aligned to the window size.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESET  in  1  asynchronous, active-high reset.
AWADDR  in  ADDR_WIDTH  write byte address.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address ready.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte-lane write enables.
WVALID  in  1  write data valid.
WREADY  out  1  write data ready.
BRESP  out  2  write response: 00 OKAY, 11 DECERR.
BVALID  out  1  write response valid.
BREADY  in  1  write response ready.
ARADDR  in  ADDR_WIDTH  read byte address.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address ready.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  read response: 00 OKAY, 11 DECERR.
RVALID  out  1  read data valid.
RREADY  in  1  read data ready.

Behaviour:
- Reset (ARESET=1, asynchronous):
  - All ready and valid outputs = 0.
  - BRESP, RRESP, RDATA = 0.
  - Holding registers cleared; both FSMs return to IDLE.
  - Memory contents are not reset.
- First rising edge after ARESET falls: AWREADY=WREADY=ARREADY=1.
- Address decode:
  - OFFS = log2(DATA_WIDTH/8).
  - Word index = (addr - BASE_ADDR) >> OFFS.
  - Hit when BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*(DATA_WIDTH/8).
  - Low OFFS address bits are ignored (unaligned accesses are forced to alignment).
- Write FSM, states W_COLLECT and W_RESP:
  - W_COLLECT: an AW handshake latches AWADDR and drops AWREADY. A W handshake latches WDATA/WSTRB and drops WREADY.
  - AW and W may arrive in either order or in the same cycle, with any gap between them.
  - On the edge where both halves are held: on a hit, write each byte lane whose WSTRB bit is 1 and respond BRESP=00; on a miss, leave memory unchanged and respond BRESP=11. Assert BVALID and go to W_RESP.
  - Write-to-BVALID latency: 1 cycle after the later of the two handshakes.
  - W_RESP: BVALID and BRESP hold stable until BREADY. At the B handshake, BVALID falls and AWREADY=WREADY=1 on the next cycle.
  - AWREADY and WREADY stay 0 throughout W_RESP; one write is outstanding at a time.
  - WSTRB=0 on a hit gives an OKAY response with no memory change.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: ARREADY=1. At the AR handshake, RDATA is registered from memory (or 0 on a miss), RRESP = 00 on a hit or 11 on a miss, RVALID=1, ARREADY=0. Go to R_DATA.
  - Read latency: RVALID asserts 1 cycle after the AR handshake.
  - R_DATA: RDATA, RRESP and RVALID hold stable until RREADY. At the R handshake, RVALID=0 and ARREADY=1 on the next cycle.
  - Peak throughput: one read every 2 cycles.
- Read and write channels run fully independently.
  - Same-edge write commit and AR handshake to the same word: the read returns the pre-write data.
  - A read handshaken in any later cycle sees the new data.
- Valid signals never depend combinationally on ready inputs. There are no combinational paths from inputs to outputs.
- ARESET asserted mid-transaction:
  - A partially collected write is discarded with no memory update.
  - A pending B or R response is dropped.
  - A write already committed to memory remains.

Test Plan:
1. Reset, then AW and W in the same cycle: addr 0x10, data 0xDEADBEEF, WSTRB 0xF -> BVALID one cycle later, BRESP=00. Then AR 0x10 -> RDATA=0xDEADBEEF, RRESP=00, RVALID one cycle after AR.
2. W first, AW three cycles later: addr 0x20, data 0x11223344, WSTRB 0x5. Prior contents 0xAABBCCDD -> read 0x20 returns 0xAA22CC44.
3. Out-of-range accesses: AW at BASE_ADDR+MEM_DEPTH*4 -> BRESP=11 and no memory word changes. AR at the same address -> RRESP=11, RDATA=0.
4. Backpressure: BREADY and RREADY held low for 5 cycles -> BVALID/BRESP and RVALID/RDATA stay stable. AWREADY, WREADY and ARREADY remain 0 until the respective handshake.
5. Same-edge collision: word 0x40 holds 0x0. Write 0x55AA55AA completes on the same edge as an AR to 0x40 -> the read returns 0x0. The next read of 0x40 returns 0x55AA55AA.
6. ARESET pulsed after the AW handshake but before W -> no memory change, BVALID=0, all ready signals high one cycle after release. Repeat test 1 with DATA_WIDTH=64, unaligned addr 0x0C -> accesses word 1.
